alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Registered, handshaked successor to the combinational ALU decoder.
- Decodes ALU_Op/funct into the 4-bit ALU_Control code, then holds it for a parametrised number of cycles for multi-cycle ops (multiply, divide).
- Raises a busy/stall flag while those ops run and delivers each result code through a valid/ready output stage.
- Sits between the main control unit and the ALU/datapath; alu_busy feeds the PC/pipeline stall logic.

Parameters:
- N, 6, width of funct field
- M, 2, width of ALU_Op
- L, 4, width of ALU_Control
- MUL_CYCLES, 4, execute latency of multiply (0101); legal range >=1
- DIV_CYCLES, 16, execute latency of divide (0110); legal range >=1
- CNT_W, $clog2(max(MUL_CYCLES,DIV_CYCLES)+1), width of the cycle counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request carries a valid ALU_Op/funct
- in_ready  out  1  sequencer can accept a request this cycle
- ALU_Op  in  M  class: 00 add, 01 sub, 1x R-type (use funct)
- funct  in  N  R-type function code
- flush  in  1  synchronous abort of in-flight/pending op
- out_ready  in  1  consumer accepts ALU_Control this cycle
- out_valid  out  1  ALU_Control/illegal are valid
- ALU_Control  out  L  registered control code
- illegal  out  1  undefined funct under ALU_Op=1x
- alu_busy  out  1  multi-cycle op executing (stall request)

Behaviour:
- Decode table (shared LUT):
  - ALU_Op 00 -> 0001; ALU_Op 01 -> 0010.
  - ALU_Op 1x, funct 000000..001001 -> 0011,0100,0101,0110,0111,1000,1001,1010,1011,1100.
  - Any other funct -> 0000 with illegal=1.
- States:
  - IDLE: no pending output.
  - EXEC: multi-cycle countdown.
  - RESP: out_valid=1, waiting for out_ready.
- in_ready = !flush && (state==IDLE || (state==RESP && out_ready)).
- accept = in_valid && in_ready. On accept, ALU_Control and illegal are registered from the decode.
- Single-cycle op (any code except 0101/0110, or whose CYCLES==1):
  - Next state RESP; out_valid in the cycle after accept (latency 1).
  - Back-to-back accepts give throughput 1/cycle when out_ready is held high.
- Multi-cycle op (0101 with MUL_CYCLES>=2, 0110 with DIV_CYCLES>=2):
  - On accept, next state EXEC with cnt=CYCLES-1.
  - In EXEC: cnt decrements each cycle; ALU_Control is held; alu_busy=1; in_ready=0; out_valid=0.
  - When cnt==1, next state RESP. Accept at cycle t gives out_valid at t+CYCLES.
- RESP:
  - Outputs are held stable while out_ready=0.
  - out_ready=1 with no new accept -> IDLE, out_valid=0 next cycle.
  - out_ready=1 with accept -> load the new op, same rules as above.
- flush: takes priority over everything except rst.
  - Next cycle: state IDLE, out_valid=0, alu_busy=0, cnt=0, illegal=0.
  - ALU_Control is held at its last value.
  - A flush in the same cycle as in_valid performs no accept.
- rst (async): state IDLE, ALU_Control=0000, out_valid=0, illegal=0, alu_busy=0, cnt=0.
  - A reset mid-EXEC aborts the op with no out_valid.
- alu_busy is decoded from state==EXEC only, glitch-free from registers.
- in_valid in EXEC is ignored (in_ready=0). The requester must hold it.

Decomposition:
- Package alu_pkg:
  - ALU_Op encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE).
  - funct constants.
  - ALU_Control codes (CTL_ADD..CTL_SLT, CTL_ILLEGAL=0000).
  - State enum (IDLE, EXEC, RESP).
  - Function is_multicycle(ctl).
- Sub-module alu_ctrl_lut: purely combinational ALU_Op/funct -> {ALU_Control, illegal}, reusable by other control paths.

Test Plan:
1. Reset then ALU_Op=00 accept at t, out_ready=1 -> out_valid at t+1, ALU_Control=0001, alu_busy never 1.
2. Back-to-back R-type funct 000100, 000101, 000110 with out_ready=1 -> outputs 0111, 1000, 1001 on consecutive cycles, in_ready stays 1.
3. Multiply (ALU_Op=10, funct 000010), MUL_CYCLES=4, accept at t -> alu_busy=1 during t+1..t+3, in_ready=0, out_valid at t+4 with ALU_Control=0101.
4. Divide accepted, out_ready=0 on completion -> out_valid and 0110 held 3 cycles until out_ready=1, then IDLE.
5. funct 111111 with ALU_Op=11 -> ALU_Control=0000, illegal=1, latency 1.
6. flush at cycle t+2 of a divide, plus rst asserted mid-EXEC in a second run -> IDLE next cycle (flush) or immediately (rst), no out_valid, alu_busy=0; a flush coinciding with in_valid produces no accept.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control encodings, sequencer states and decode helpers.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] F_AND = 6'd0;
    localparam logic [5:0] F_OR  = 6'd1;
    localparam logic [5:0] F_MUL = 6'd2;
    localparam logic [5:0] F_DIV = 6'd3;
    localparam logic [5:0] F_XOR = 6'd4;
    localparam logic [5:0] F_NOR = 6'd5;
    localparam logic [5:0] F_SLL = 6'd6;
    localparam logic [5:0] F_SRL = 6'd7;
    localparam logic [5:0] F_SRA = 6'd8;
    localparam logic [5:0] F_SLT = 6'd9;

    localparam logic [3:0] CTL_ILLEGAL = 4'b0000;
    localparam logic [3:0] CTL_ADD     = 4'b0001;
    localparam logic [3:0] CTL_SUB     = 4'b0010;
    localparam logic [3:0] CTL_AND     = 4'b0011;
    localparam logic [3:0] CTL_OR      = 4'b0100;
    localparam logic [3:0] CTL_MUL     = 4'b0101;
    localparam logic [3:0] CTL_DIV     = 4'b0110;
    localparam logic [3:0] CTL_XOR     = 4'b0111;
    localparam logic [3:0] CTL_NOR     = 4'b1000;
    localparam logic [3:0] CTL_SLL     = 4'b1001;
    localparam logic [3:0] CTL_SRL     = 4'b1010;
    localparam logic [3:0] CTL_SRA     = 4'b1011;
    localparam logic [3:0] CTL_SLT     = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

    function automatic logic is_multicycle(input logic [3:0] ctl);
        return (ctl == CTL_MUL) || (ctl == CTL_DIV);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_lut.sv
// Combinational ALU_Op/funct to ALU_Control lookup, shared by control paths.
module alu_ctrl_lut
    import alu_pkg::*;
#(
    parameter int N = 6,
    parameter int M = 2,
    parameter int L = 4
) (
    input  logic [M-1:0] alu_op_i,
    input  logic [N-1:0] funct_i,
    output logic [L-1:0] ctl_o,
    output logic         illegal_o
);

    always_comb begin
        ctl_o     = L'(CTL_ILLEGAL);
        illegal_o = 1'b0;
        if (!alu_op_i[M-1]) begin
            ctl_o = alu_op_i[0] ? L'(CTL_SUB) : L'(CTL_ADD);
        end else begin
            case (funct_i)
                N'(F_AND): ctl_o = L'(CTL_AND);
                N'(F_OR):  ctl_o = L'(CTL_OR);
                N'(F_MUL): ctl_o = L'(CTL_MUL);
                N'(F_DIV): ctl_o = L'(CTL_DIV);
                N'(F_XOR): ctl_o = L'(CTL_XOR);
                N'(F_NOR): ctl_o = L'(CTL_NOR);
                N'(F_SLL): ctl_o = L'(CTL_SLL);
                N'(F_SRL): ctl_o = L'(CTL_SRL);
                N'(F_SRA): ctl_o = L'(CTL_SRA);
                N'(F_SLT): ctl_o = L'(CTL_SLT);
                default:   illegal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU control sequencer: decode, multi-cycle hold, valid/ready output.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int N          = 6,
    parameter int M          = 2,
    parameter int L          = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16,
    parameter int CNT_W      =
        $clog2((MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] ALU_Op,
    input  logic [N-1:0] funct,
    input  logic         flush,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [L-1:0] ALU_Control,
    output logic         illegal,
    output logic         alu_busy
);

    state_e           state_q, state_d;
    logic [L-1:0]     ctl_q, ctl_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, busy_q;

    logic [L-1:0]     lut_ctl;
    logic             lut_ill;
    logic [CNT_W-1:0] lut_cnt;
    logic             lut_multi;
    logic             accept;

    alu_ctrl_lut #(.N(N), .M(M), .L(L)) u_lut (
        .alu_op_i  (ALU_Op),
        .funct_i   (funct),
        .ctl_o     (lut_ctl),
        .illegal_o (lut_ill)
    );

    // A latency of 1 degenerates a multi-cycle op into a single-cycle one.
    assign lut_cnt   = (lut_ctl == L'(CTL_MUL)) ? CNT_W'(MUL_CYCLES - 1)
                                                : CNT_W'(DIV_CYCLES - 1);
    assign lut_multi = is_multicycle(4'(lut_ctl)) && (lut_cnt != '0);

    assign in_ready = !flush && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_RESP) && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        ctl_d   = ctl_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_IDLE;
            ill_d   = 1'b0;
            cnt_d   = '0;
        end else if (accept) begin
            ctl_d = lut_ctl;
            ill_d = lut_ill;
            if (lut_multi) begin
                state_d = ST_EXEC;
                cnt_d   = lut_cnt;
            end else begin
                state_d = ST_RESP;
                cnt_d   = '0;
            end
        end else begin
            unique case (state_q)
                ST_EXEC: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags come straight from flops so the stall line never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ctl_q   <= '0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
            valid_q <= (state_d == ST_RESP);
            busy_q  <= (state_d == ST_EXEC);
        end
    end

    assign out_valid   = valid_q;
    assign alu_busy    = busy_q;
    assign ALU_Control = ctl_q;
    assign illegal     = ill_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer against a cycle-count reference model.
module tb_alu_op_sequencer;

    localparam int MULC = 4;
    localparam int DIVC = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] ALU_Op = 2'b00;
    logic [5:0] funct = 6'd0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [3:0] ALU_Control;
    logic       illegal;
    logic       alu_busy;

    alu_op_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALU_Op      (ALU_Op),
        .funct       (funct),
        .flush       (flush),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .ALU_Control (ALU_Control),
        .illegal     (illegal),
        .alu_busy    (alu_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ctl;
        logic       ill;
        int         due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   seen = 0;

    // model state: EXEC cycles still to run, and a result waiting for out_ready
    int         left = 0;
    bit         resp = 0;
    bit         after_flush = 0;
    logic [3:0] last_ctl = 4'd0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    function automatic void ref_dec(input logic [1:0] op, input logic [5:0] f,
                                    output logic [3:0] c, output logic il);
        il = 1'b0;
        if (op == 2'b00)      c = 4'd1;
        else if (op == 2'b01) c = 4'd2;
        else if (f < 6'd10)   c = 4'(f + 6'd3);
        else begin
            c  = 4'd0;
            il = 1'b1;
        end
    endfunction

    function automatic int ref_lat(input logic [3:0] c);
        if (c == 4'd5) return MULC;
        if (c == 4'd6) return DIVC;
        return 1;
    endfunction

    task automatic step(input logic v, input logic [1:0] op, input logic [5:0] f,
                        input logic ordy, input logic fl);
        bit         exp_rdy;
        logic [3:0] c;
        logic       il;
        int         lat;
        @(posedge clk);
        #1;
        in_valid  = v;
        ALU_Op    = op;
        funct     = f;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        #1;
        if (after_flush) begin
            chk("flush_ctl_hold", int'(ALU_Control), int'(last_ctl));
            chk("flush_illegal", int'(illegal), 0);
        end
        exp_rdy = !fl && ((!resp && left == 0) || (resp && ordy));
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        chk("alu_busy", int'(alu_busy), (left > 0) ? 1 : 0);
        after_flush = fl;
        if (fl) begin
            left = 0;
            resp = 0;
            q.delete();
            seen = 0;
        end else if (v && exp_rdy) begin
            ref_dec(op, f, c, il);
            lat = ref_lat(c);
            q.push_back('{ctl: c, ill: il, due: cyc + lat});
            last_ctl = c;
            resp = (lat == 1);
            left = lat - 1;
        end else if (left > 0) begin
            left--;
            if (left == 0) resp = 1;
        end else if (resp && ordy) begin
            resp = 0;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(alu_busy), 0);
        chk("rst_ctl", int'(ALU_Control), 0);
        chk("rst_illegal", int'(illegal), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        seen        = 0;
        left        = 0;
        resp        = 0;
        after_flush = 0;
        last_ctl    = 4'd0;
    endtask

    // monitor: every presented output must match the head of the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    if (!seen) begin
                        chk("out_latency", cyc, q[0].due);
                        seen = 1;
                    end
                    chk("out_ctl", int'(ALU_Control), int'(q[0].ctl));
                    chk("out_illegal", int'(illegal), int'(q[0].ill));
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_busy", int'(alu_busy), 0);
        chk("reset_ctl", int'(ALU_Control), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        #1;
        rst = 1'b0;

        // add, back-to-back R-type, multiply, stalled divide, illegal funct
        step(1, 2'b00, 6'd0, 1, 0);
        step(0, 2'b00, 6'd0, 1, 0);
        step(1, 2'b10, 6'd4, 1, 0);
        step(1, 2'b10, 6'd5, 1, 0);
        step(1, 2'b10, 6'd6, 1, 0);
        step(0, 2'b00, 6'd0, 1, 0);
        step(1, 2'b10, 6'd2, 1, 0);
        repeat (5) step(0, 2'b00, 6'd0, 1, 0);
        step(1, 2'b10, 6'd3, 0, 0);
        repeat (18) step(0, 2'b00, 6'd0, 0, 0);
        step(0, 2'b00, 6'd0, 1, 0);
        step(1, 2'b11, 6'd63, 1, 0);
        step(0, 2'b00, 6'd0, 1, 0);

        // flush two cycles into a divide, then flush racing an in_valid
        step(1, 2'b10, 6'd3, 1, 0);
        step(0, 2'b00, 6'd0, 1, 0);
        step(0, 2'b00, 6'd0, 1, 1);
        step(1, 2'b10, 6'd4, 1, 1);
        step(0, 2'b00, 6'd0, 1, 0);

        // reset in the middle of a divide
        step(1, 2'b10, 6'd3, 1, 0);
        repeat (3) step(0, 2'b00, 6'd0, 1, 0);
        do_reset();
        step(0, 2'b00, 6'd0, 1, 0);

        for (int i = 0; i < 1500; i++) begin
            logic [5:0] f;
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(10, 63))
                                            : 6'($urandom_range(0, 9));
            step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), f,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end

        repeat (40) step(0, 2'b00, 6'd0, 1, 0);
        chk("scoreboard_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
